// File: rtl/mlp_train_sequencer.sv
// Training-run sequencer: buffers samples, then steps an MLP through settle/update per sample.
// Define MLP_LR_DECAY_EN to halve the learning rate at each epoch boundary.
module mlp_train_sequencer #(
  parameter int INPUTS = 2,
  parameter int OUTPUTS = 1,
  parameter int DEPTH = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int EPOCH_W = 16,
  parameter int SFP_W = 16,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           clr_buf,
  input  logic [EPOCH_W-1:0]             num_epochs,
  input  logic [SFP_W-1:0]               lr_init,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [INPUTS-1:0][SFP_W-1:0]   ld_values,
  input  logic [OUTPUTS-1:0][SFP_W-1:0]  ld_expected,
  output logic [INPUTS-1:0][SFP_W-1:0]   mlp_values,
  output logic [OUTPUTS-1:0][SFP_W-1:0]  mlp_expected,
  output logic                           mlp_training,
  output logic [SFP_W-1:0]               mlp_learning_rate,
  output logic                           busy,
  output logic                           done,
  output logic [EPOCH_W-1:0]             epoch_count,
  output logic [IW-1:0]                  sample_idx
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [CW-1:0] count;
  logic [SW-1:0] settle_cnt;
  logic [EPOCH_W-1:0] epochs_lat;
  logic [SFP_W-1:0] lr;

  logic [INPUTS-1:0][SFP_W-1:0] val_mem [DEPTH];
  logic [OUTPUTS-1:0][SFP_W-1:0] exp_mem [DEPTH];

  logic load_fire;
  logic can_start;
  logic last_sample;
  logic settle_last;
  logic [EPOCH_W-1:0] epoch_inc;

  assign ld_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire = ld_valid && ld_ready && !clr_buf;
  assign can_start = start && (count != '0)
                   && ((state == IDLE) || (state == DONE));
  assign last_sample = (CW'(sample_idx) == count - CW'(1));
  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign epoch_inc = epoch_count + EPOCH_W'(1);

  assign busy = (state == SETTLE) || (state == UPDATE);
  assign done = (state == DONE);
  assign mlp_training = (state == UPDATE);
  assign mlp_learning_rate = busy ? lr : '0;
  assign mlp_values = busy ? val_mem[sample_idx] : '0;
  assign mlp_expected = busy ? exp_mem[sample_idx] : '0;

  // Sample storage is not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && load_fire) begin
      val_mem[count[IW-1:0]] <= ld_values;
      exp_mem[count[IW-1:0]] <= ld_expected;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      settle_cnt <= '0;
      epochs_lat <= '0;
      lr <= '0;
      epoch_count <= '0;
      sample_idx <= '0;
    end else begin
      if (state == IDLE) begin
        if (clr_buf) count <= '0;
        else if (load_fire) count <= count + CW'(1);
      end
      // Abort freezes progress counters so a host can inspect them.
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (can_start) begin
              epochs_lat <= num_epochs;
              lr <= lr_init;
              epoch_count <= '0;
              sample_idx <= '0;
              settle_cnt <= '0;
              state <= (num_epochs == '0) ? DONE : SETTLE;
            end
          end
          SETTLE: begin
            if (settle_last) state <= UPDATE;
            else settle_cnt <= settle_cnt + SW'(1);
          end
          UPDATE: begin
            settle_cnt <= '0;
            if (!last_sample) begin
              sample_idx <= sample_idx + IW'(1);
              state <= SETTLE;
            end else begin
              epoch_count <= epoch_inc;
              sample_idx <= '0;
              if (epoch_inc == epochs_lat) begin
                state <= DONE;
              end else begin
                state <= SETTLE;
`ifdef MLP_LR_DECAY_EN
                lr <= $unsigned($signed(lr) >>> 1);
`endif
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Randomized bench for mlp_train_sequencer with a cycle-index reference model.
// Expected rate follows MLP_LR_DECAY_EN when the bench is built with it.
module tb_mlp_train_sequencer;
  localparam int IN = 2;
  localparam int OUT = 1;
  localparam int D = 4;
  localparam int S = 2;
  localparam int EW = 16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, abort, clr_buf, ld_valid;
  logic [EW-1:0] num_epochs;
  logic [W-1:0] lr_init;
  logic [IN-1:0][W-1:0] ld_values;
  logic [OUT-1:0][W-1:0] ld_expected;
  logic ld_ready, mlp_training, busy, done;
  logic [IN-1:0][W-1:0] mlp_values;
  logic [OUT-1:0][W-1:0] mlp_expected;
  logic [W-1:0] mlp_learning_rate;
  logic [EW-1:0] epoch_count;
  logic [1:0] sample_idx;

  int tests = 0;
  int fails = 0;
  logic [IN-1:0][W-1:0] mv [D];
  logic [OUT-1:0][W-1:0] me [D];
  int mcount = 0;

  always #5 clk = ~clk;

  mlp_train_sequencer #(
    .INPUTS(IN), .OUTPUTS(OUT), .DEPTH(D),
    .SETTLE_CYCLES(S), .EPOCH_W(EW), .SFP_W(W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .clr_buf(clr_buf), .num_epochs(num_epochs),
    .lr_init(lr_init), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_values(ld_values),
    .ld_expected(ld_expected), .mlp_values(mlp_values),
    .mlp_expected(mlp_expected),
    .mlp_training(mlp_training),
    .mlp_learning_rate(mlp_learning_rate),
    .busy(busy), .done(done),
    .epoch_count(epoch_count), .sample_idx(sample_idx)
  );

  function automatic logic [W-1:0] lr_at(logic [W-1:0] r, int ep);
    logic signed [W-1:0] s;
    s = r;
`ifdef MLP_LR_DECAY_EN
    s = s >>> ep;
`else
    if (ep < 0) s = '0;
`endif
    return s;
  endfunction

  task automatic reset_dut();
    rst = 1; start = 0; abort = 0; clr_buf = 0;
    ld_valid = 0; num_epochs = '0; lr_init = '0;
    ld_values = '0; ld_expected = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    mcount = 0;
  endtask

  task automatic load_n(int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1;
      ld_values[0] = W'($urandom);
      ld_values[1] = W'($urandom);
      ld_expected[0] = W'($urandom);
      mv[mcount] = ld_values;
      me[mcount] = ld_expected;
      mcount++;
      @(negedge clk);
    end
    ld_valid = 0;
  endtask

  task automatic reload(int n);
    abort = 1;
    @(negedge clk);
    abort = 0;
    clr_buf = 1;
    @(negedge clk);
    clr_buf = 0;
    mcount = 0;
    load_n(n);
  endtask

  task automatic run_check(int e, logic [W-1:0] r, string nm);
    int n, pulses, idx, ep, total;
    logic tr;
    n = mcount;
    total = e * n * (S + 1);
    num_epochs = EW'(e);
    lr_init = r;
    start = 1;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int t = 0; t < total; t++) begin
      idx = (t / (S + 1)) % n;
      ep = t / ((S + 1) * n);
      tr = ((t % (S + 1)) == S);
      if (mlp_training) pulses++;
      tests++;
      if ({busy, done, mlp_training, sample_idx, epoch_count}
          !== {1'b1, 1'b0, tr, 2'(idx), EW'(ep)}) begin
        fails++;
        $display("FAIL %s ctl t=%0d got b%b d%b tr%b i%0d e%0d want tr%b i%0d e%0d",
                 nm, t, busy, done, mlp_training, sample_idx,
                 epoch_count, tr, idx, ep);
      end
      tests++;
      if ({mlp_values, mlp_expected, mlp_learning_rate}
          !== {mv[idx], me[idx], lr_at(r, ep)}) begin
        fails++;
        $display("FAIL %s data t=%0d got %h %h %h want %h %h %h",
                 nm, t, mlp_values, mlp_expected,
                 mlp_learning_rate, mv[idx], me[idx], lr_at(r, ep));
      end
      @(negedge clk);
    end
    tests++;
    if ({done, busy, mlp_training, epoch_count, mlp_learning_rate,
         mlp_values} !== {1'b1, 1'b0, 1'b0, EW'(e), W'(0), 32'd0}) begin
      fails++;
      $display("FAIL %s end got d%b b%b tr%b e%0d lr%h want d1 b0 tr0 e%0d lr0",
               nm, done, busy, mlp_training, epoch_count,
               mlp_learning_rate, e);
    end
    tests++;
    if (pulses != e * n) begin
      fails++;
      $display("FAIL %s pulses got %0d want %0d", nm, pulses, e * n);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    tests++;
    if ({busy, done, mlp_training, ld_ready, epoch_count, sample_idx,
         mlp_learning_rate, mlp_values, mlp_expected}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 16'd0, 32'd0, 16'd0}) begin
      fails++;
      $display("FAIL reset got b%b d%b tr%b rdy%b e%0d i%0d lr%h",
               busy, done, mlp_training, ld_ready, epoch_count,
               sample_idx, mlp_learning_rate);
    end
  endtask

  task automatic test_buffer_full();
    reload(4);
    tests++;
    if (ld_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready got %b want 0", ld_ready);
    end
    ld_valid = 1;
    @(negedge clk);
    tests++;
    if (ld_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifth_load got %b want 0", ld_ready);
    end
    clr_buf = 1;
    @(negedge clk);
    clr_buf = 0;
    ld_valid = 0;
    mcount = 0;
    tests++;
    if (ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_ready got %b want 1", ld_ready);
    end
    // clr_buf with ld_valid together must leave count at 0.
    ld_valid = 1;
    clr_buf = 1;
    @(negedge clk);
    clr_buf = 0;
    ld_valid = 0;
    load_n(3);
    tests++;
    if (ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL three_ready got %b want 1", ld_ready);
    end
    load_n(1);
    tests++;
    if (ld_ready !== 1'b0) begin
      fails++;
      $display("FAIL four_ready got %b want 0", ld_ready);
    end
  endtask

  task automatic test_start_guard();
    reset_dut();
    num_epochs = 2;
    start = 1;
    @(negedge clk);
    start = 0;
    tests++;
    if ({busy, done, ld_ready} !== 3'b001) begin
      fails++;
      $display("FAIL empty_start got b%b d%b r%b want b0 d0 r1",
               busy, done, ld_ready);
    end
    load_n(2);
    num_epochs = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({done, busy, mlp_training, ld_ready} !== 4'b1000) begin
        fails++;
        $display("FAIL zero_epochs c%0d got d%b b%b tr%b r%b want d1 b0 tr0 r0",
                 i, done, busy, mlp_training, ld_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    reload(4);
    num_epochs = 2;
    lr_init = W'($urandom);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    tests++;
    if ({mlp_training, sample_idx} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL abort_pre got tr%b i%0d want tr1 i1",
               mlp_training, sample_idx);
    end
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    tests++;
    if ({busy, done, mlp_training, sample_idx, epoch_count,
         mlp_learning_rate, mlp_values}
        !== {1'b0, 1'b0, 1'b0, 2'd1, 16'd0, 16'd0, 32'd0}) begin
      fails++;
      $display("FAIL abort got b%b d%b tr%b i%0d e%0d lr%h want idle i1 e0",
               busy, done, mlp_training, sample_idx, epoch_count,
               mlp_learning_rate);
    end
    run_check(1, W'($urandom), "after_abort");
  endtask

  task automatic test_rst_mid();
    reload(3);
    num_epochs = 2;
    lr_init = 16'h1234;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    mcount = 0;
    tests++;
    if ({busy, done, mlp_training, ld_ready, epoch_count, sample_idx,
         mlp_learning_rate, mlp_values, mlp_expected}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 16'd0, 32'd0, 16'd0}) begin
      fails++;
      $display("FAIL rst_mid got b%b d%b tr%b r%b e%0d i%0d lr%h",
               busy, done, mlp_training, ld_ready, epoch_count,
               sample_idx, mlp_learning_rate);
    end
  endtask

  task automatic test_back_to_back();
    reload(2);
    run_check(2, W'($urandom), "b2b_a");
    run_check(1, W'($urandom), "b2b_b");
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 4; k++) begin
      reload($urandom_range(1, 4));
      run_check($urandom_range(1, 3), W'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    reload(4);
    run_check(2, 16'h0100, "basic_4x2");
    test_buffer_full();
    test_start_guard();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    reload(3);
    run_check(3, 16'h0100, "lr_epochs");
    test_random_runs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlp_train_sequencer.md
MLP_TRAIN_SEQUENCER -- requirements
Module: mlp_train_sequencer

Interface
REQ-001 SHALL have parameter INPUTS, default 2: sfp features per sample.
REQ-002 SHALL have parameter OUTPUTS, default 1: sfp targets per sample.
REQ-003 SHALL have parameter DEPTH, default 4: sample buffer entries.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, minimum 1: forward-settle cycles per sample.
REQ-005 SHALL have parameter EPOCH_W, default 16: epoch counter width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: begin training run.
REQ-009 SHALL have port abort, input, 1: cancel run.
REQ-010 SHALL have port clr_buf, input, 1: empty sample buffer.
REQ-011 SHALL have port num_epochs, input, EPOCH_W: epochs to run, sampled at start.
REQ-012 SHALL have port lr_init, input, sfp: learning rate, sampled at start.
REQ-013 SHALL have port ld_valid, input, 1: load-sample valid.
REQ-014 SHALL have port ld_ready, output, 1: load-sample ready.
REQ-015 SHALL have port ld_values, input, sfp[INPUTS]: sample features.
REQ-016 SHALL have port ld_expected, input, sfp[OUTPUTS]: sample targets.
REQ-017 SHALL have port mlp_values, output, sfp[INPUTS]: to MLP values.
REQ-018 SHALL have port mlp_expected, output, sfp[OUTPUTS]: to MLP expected.
REQ-019 SHALL have port mlp_training, output, 1: to MLP training.
REQ-020 SHALL have port mlp_learning_rate, output, sfp: to MLP learning_rate.
REQ-021 SHALL have ports busy and done, output, 1 each: status.
REQ-022 SHALL have ports epoch_count (EPOCH_W) and sample_idx ($clog2(DEPTH)), output: progress.

Function
REQ-023 SHALL implement states IDLE, SETTLE, UPDATE, DONE.
REQ-024 In IDLE, ld_ready SHALL equal (count < DEPTH); a ld_valid&&ld_ready cycle SHALL write the sample at index count and increment count; ld_ready SHALL be 0 in all other states.
REQ-025 clr_buf in IDLE SHALL set count to 0 next cycle, taking priority over a same-cycle load; clr_buf outside IDLE SHALL be ignored.
REQ-026 start in IDLE or DONE with count>0 and num_epochs>0 SHALL latch num_epochs and lr_init, clear epoch_count and sample_idx, clear done, and enter SETTLE.
REQ-027 start with count==0 SHALL be ignored; start with num_epochs==0 and count>0 SHALL go directly to DONE.
REQ-028 start while in SETTLE or UPDATE SHALL be ignored.
REQ-029 mlp_values and mlp_expected SHALL drive buffer entry sample_idx whenever busy; in IDLE and DONE they SHALL drive zero.
REQ-030 SETTLE SHALL last exactly SETTLE_CYCLES cycles with mlp_training=0, then go to UPDATE.
REQ-031 UPDATE SHALL last exactly 1 cycle with mlp_training=1; mlp_training SHALL be 0 in every other state.
REQ-032 Leaving UPDATE with sample_idx<count-1 SHALL increment sample_idx and return to SETTLE.
REQ-033 Leaving UPDATE with sample_idx==count-1 SHALL increment epoch_count, zero sample_idx, and enter DONE if the new epoch_count equals the latched num_epochs, else SETTLE.
REQ-034 Each sample SHALL thus take SETTLE_CYCLES+1 cycles; a run SHALL take num_epochs*count*(SETTLE_CYCLES+1) cycles from start to DONE.
REQ-035 busy SHALL be 1 exactly in SETTLE and UPDATE.
REQ-036 done SHALL be 1 in DONE and hold until start or rst; DONE SHALL accept no loads.
REQ-037 abort in any state SHALL enter IDLE next cycle with mlp_training=0 and done=0; epoch_count and sample_idx SHALL hold; abort SHALL take priority over start and over UPDATE advance.
REQ-038 mlp_learning_rate SHALL equal the latched rate while busy and 0 otherwise.

Reset
REQ-039 rst SHALL, on the next edge and regardless of state, force IDLE, set count, sample_idx, epoch_count, latched rate, mlp_training, busy, done and all mlp_* outputs to 0; buffer contents need not be cleared.
REQ-040 rst SHALL take priority over abort, start, clr_buf and loads.

Configuration
REQ-041 With macro MLP_LR_DECAY_EN defined, the latched rate SHALL arithmetic-shift right by 1 at each epoch increment that does not enter DONE.
REQ-042 Without MLP_LR_DECAY_EN, the latched rate SHALL remain lr_init for the whole run.

Verification
REQ-043 Load 4 samples, num_epochs=2, SETTLE_CYCLES=2, start -> busy for 24 cycles, mlp_training pulses 8 times, 1 cycle each, 3 cycles apart, done=1, epoch_count=2.
REQ-044 Load 4 samples, apply a 5th ld_valid -> ld_ready=0, count stays 4; clr_buf -> ld_ready=1, count=0.
REQ-045 start with count=0 -> stays IDLE, busy=0; start with num_epochs=0 and count=2 -> done=1 next cycle, no training pulse.
REQ-046 abort asserted during UPDATE of sample 1 -> next cycle IDLE, mlp_training=0, sample_idx=1; rst mid-run -> all outputs 0.
REQ-047 lr_init=0x0100, 3 epochs with MLP_LR_DECAY_EN -> mlp_learning_rate 0x0100, 0x0080, 0x0040 per epoch; without the macro -> 0x0100 throughout.
